// File: rtl/regfile_pkg.sv
// Shared definitions for the scoreboarded register file: clear-FSM state
// encoding and the default geometry.
package regfile_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_NREGS = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: array lookup plus optional same-cycle
// forwarding of the write data and of the resulting pending bit.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NREGS  = DEF_NREGS,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic [WIDTH-1:0] regs_i [NREGS],
    input  logic [NREGS-1:0] pend_i,
    input  logic [AW-1:0]    addr_i,
    input  logic             wr_acc_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             mark_i,
    input  logic [AW-1:0]    mark_idx_i,
    output logic [WIDTH-1:0] data_o,
    output logic             pend_o
);

    logic fwd;

    assign fwd = (BYPASS != 0) && wr_acc_i && (wr_addr_i == addr_i);

    // A forwarded write clears the pending bit unless a mark lands on it too.
    always_comb begin
        data_o = regs_i[addr_i];
        pend_o = pend_i[addr_i];
        if (fwd) begin
            data_o = wr_data_i;
            pend_o = mark_i && (mark_idx_i == addr_i);
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with per-entry pending (scoreboard) bits, write-to-read
// forwarding and a sequential clear-all engine that walks one entry per cycle.
module reg_file_sb
    import regfile_pkg::*;
#(
    parameter int  WIDTH  = DEF_WIDTH,
    parameter int  NREGS  = DEF_NREGS,
    parameter int  BYPASS = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Ld_REG,
    input  logic [AW-1:0]    DR,
    input  logic [WIDTH-1:0] In,
    input  logic [AW-1:0]    SR1,
    input  logic [AW-1:0]    SR2,
    output logic [WIDTH-1:0] SR1_out,
    output logic [WIDTH-1:0] SR2_out,
    input  logic             Mark,
    input  logic [AW-1:0]    Mark_idx,
    output logic             SR1_pend,
    output logic             SR2_pend,
    input  logic             Clr_req,
    output logic             Clr_busy
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    clr_state_e       state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [NREGS-1:0] pend_q, pend_d;
    logic             busy;
    logic             wr_acc;

    assign busy     = (state_q == CLEAR);
    assign Clr_busy = busy;
    assign wr_acc   = Ld_REG && !busy;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (Clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Per-entry next state; a mark beats both a write and the clear sweep.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_entry
            localparam logic [AW-1:0] IDX = AW'(gi);
            logic wr_hit;
            logic clr_hit;
            logic mark_hit;

            assign wr_hit   = wr_acc && (DR == IDX);
            assign clr_hit  = busy && (cnt_q == IDX);
            assign mark_hit = Mark && (Mark_idx == IDX);

            assign regs_d[gi] = clr_hit ? '0 : (wr_hit ? In : regs_q[gi]);
            assign pend_d[gi] = mark_hit ? 1'b1
                              : ((clr_hit || wr_hit) ? 1'b0 : pend_q[gi]);
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            regs_q  <= regs_d;
        end
    end

    regfile_rdport #(
        .WIDTH (WIDTH),
        .NREGS (NREGS),
        .BYPASS(BYPASS),
        .AW    (AW)
    ) u_rd1 (
        .regs_i    (regs_q),
        .pend_i    (pend_q),
        .addr_i    (SR1),
        .wr_acc_i  (wr_acc),
        .wr_addr_i (DR),
        .wr_data_i (In),
        .mark_i    (Mark),
        .mark_idx_i(Mark_idx),
        .data_o    (SR1_out),
        .pend_o    (SR1_pend)
    );

    regfile_rdport #(
        .WIDTH (WIDTH),
        .NREGS (NREGS),
        .BYPASS(BYPASS),
        .AW    (AW)
    ) u_rd2 (
        .regs_i    (regs_q),
        .pend_i    (pend_q),
        .addr_i    (SR2),
        .wr_acc_i  (wr_acc),
        .wr_addr_i (DR),
        .wr_data_i (In),
        .mark_i    (Mark),
        .mark_idx_i(Mark_idx),
        .data_o    (SR2_out),
        .pend_o    (SR2_pend)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed vector table, clear/reset sequences,
// randomized traffic against an array model, and a 16x32 instance.
module tb_reg_file_sb;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Shared stimulus for the 8x16 BYPASS=1 and BYPASS=0 instances
    logic        Reset, Ld_REG, Mark, Clr_req;
    logic [2:0]  DR, SR1, SR2, Mark_idx;
    logic [15:0] In;
    logic [15:0] b_sr1_out, b_sr2_out, n_sr1_out, n_sr2_out;
    logic        b_sr1_pend, b_sr2_pend, n_sr1_pend, n_sr2_pend, b_busy, n_busy;

    // 16x32 instance
    logic        w_reset, w_ld, w_mark, w_clr;
    logic [3:0]  w_dr, w_sr1, w_sr2, w_midx;
    logic [31:0] w_in, w_sr1_out, w_sr2_out;
    logic        w_sr1_pend, w_sr2_pend, w_busy;

    reg_file_sb #(.WIDTH(16), .NREGS(8), .BYPASS(1)) dut (
        .Clk(Clk), .Reset(Reset), .Ld_REG(Ld_REG), .DR(DR), .In(In),
        .SR1(SR1), .SR2(SR2), .SR1_out(b_sr1_out), .SR2_out(b_sr2_out),
        .Mark(Mark), .Mark_idx(Mark_idx), .SR1_pend(b_sr1_pend), .SR2_pend(b_sr2_pend),
        .Clr_req(Clr_req), .Clr_busy(b_busy)
    );

    reg_file_sb #(.WIDTH(16), .NREGS(8), .BYPASS(0)) dut_nb (
        .Clk(Clk), .Reset(Reset), .Ld_REG(Ld_REG), .DR(DR), .In(In),
        .SR1(SR1), .SR2(SR2), .SR1_out(n_sr1_out), .SR2_out(n_sr2_out),
        .Mark(Mark), .Mark_idx(Mark_idx), .SR1_pend(n_sr1_pend), .SR2_pend(n_sr2_pend),
        .Clr_req(Clr_req), .Clr_busy(n_busy)
    );

    reg_file_sb #(.WIDTH(32), .NREGS(16), .BYPASS(1)) dut_w (
        .Clk(Clk), .Reset(w_reset), .Ld_REG(w_ld), .DR(w_dr), .In(w_in),
        .SR1(w_sr1), .SR2(w_sr2), .SR1_out(w_sr1_out), .SR2_out(w_sr2_out),
        .Mark(w_mark), .Mark_idx(w_midx), .SR1_pend(w_sr1_pend), .SR2_pend(w_sr2_pend),
        .Clr_req(w_clr), .Clr_busy(w_busy)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: contents, pending bits, clear progress
    logic [15:0] m_reg [8];
    logic [7:0]  m_pend;
    bit          m_busy;
    int          m_pos;

    function automatic logic [15:0] exp_out(input logic [2:0] sr, input bit byp);
        if (byp && Ld_REG && !m_busy && DR == sr) return In;
        return m_reg[sr];
    endfunction

    function automatic logic exp_pend(input logic [2:0] sr, input bit byp);
        if (byp && Ld_REG && !m_busy && DR == sr) return Mark && (Mark_idx == sr);
        return m_pend[sr];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
        m_pend = '0;
        m_busy = 0;
        m_pos  = 0;
    endtask

    task automatic model_edge();
        if (Reset) begin
            model_reset();
        end else begin
            if (m_busy) begin
                m_reg[m_pos]  = '0;
                m_pend[m_pos] = 1'b0;
                m_pos++;
                if (m_pos == 8) m_busy = 0;
            end else begin
                if (Ld_REG) begin
                    m_reg[DR]  = In;
                    m_pend[DR] = 1'b0;
                end
                if (Clr_req) begin
                    m_busy = 1;
                    m_pos  = 0;
                end
            end
            if (Mark) m_pend[Mark_idx] = 1'b1;
        end
    endtask

    task automatic settle_and_check();
        #1;
        check("busy_b", 32'(b_busy), 32'(m_busy));
        check("busy_n", 32'(n_busy), 32'(m_busy));
        check("sr1_out_b", 32'(b_sr1_out), 32'(exp_out(SR1, 1)));
        check("sr2_out_b", 32'(b_sr2_out), 32'(exp_out(SR2, 1)));
        check("sr1_out_n", 32'(n_sr1_out), 32'(exp_out(SR1, 0)));
        check("sr2_out_n", 32'(n_sr2_out), 32'(exp_out(SR2, 0)));
        check("sr1_pend_b", 32'(b_sr1_pend), 32'(exp_pend(SR1, 1)));
        check("sr2_pend_b", 32'(b_sr2_pend), 32'(exp_pend(SR2, 1)));
        check("sr1_pend_n", 32'(n_sr1_pend), 32'(exp_pend(SR1, 0)));
        check("sr2_pend_n", 32'(n_sr2_pend), 32'(exp_pend(SR2, 0)));
    endtask

    task automatic advance();
        @(posedge Clk);
        model_edge();
        #1;
    endtask

    task automatic step();
        settle_and_check();
        advance();
    endtask

    task automatic idle_inputs();
        Reset = 0; Ld_REG = 0; Mark = 0; Clr_req = 0;
        DR = '0; SR1 = '0; SR2 = '0; Mark_idx = '0; In = '0;
    endtask

    typedef struct {
        logic        ld;
        logic [2:0]  dr;
        logic [15:0] din;
        logic [2:0]  sr1;
        logic [2:0]  sr2;
        logic        mark;
        logic [2:0]  midx;
        logic [15:0] e1_b;
        logic [15:0] e1_n;
        logic        ep2_b;
        logic        ep2_n;
    } vec_t;

    vec_t vecs [7];
    int   busy_cnt;

    initial begin
        vecs[0] = '{1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd0, 1'b0, 3'd0, 16'hBEEF, 16'h0000, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd5, 1'b1, 3'd5, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd5, 1'b0, 3'd0, 16'hBEEF, 16'hBEEF, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 3'd5, 16'h0012, 3'd5, 3'd5, 1'b0, 3'd0, 16'h0012, 16'h0000, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 3'd0, 16'h0000, 3'd5, 3'd5, 1'b0, 3'd0, 16'h0012, 16'h0012, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 3'd2, 16'hABCD, 3'd2, 3'd2, 1'b1, 3'd2, 16'hABCD, 16'h0000, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 3'd0, 16'h0000, 3'd2, 3'd2, 1'b0, 3'd0, 16'hABCD, 16'hABCD, 1'b1, 1'b1};

        idle_inputs();
        Reset = 1;
        w_reset = 1; w_ld = 0; w_mark = 0; w_clr = 0;
        w_dr = '0; w_sr1 = '0; w_sr2 = '0; w_midx = '0; w_in = '0;
        repeat (2) @(posedge Clk);
        model_reset();
        #1;
        Reset = 0;

        // Reset state across every address
        for (int i = 0; i < 8; i++) begin
            SR1 = 3'(i); SR2 = 3'(7 - i);
            settle_and_check();
            check("reset_sr1", 32'(b_sr1_out), 32'h0);
            check("reset_pend", 32'(b_sr1_pend), 32'h0);
            advance();
        end

        // Directed vector table
        for (int v = 0; v < 7; v++) begin
            Ld_REG = vecs[v].ld; DR = vecs[v].dr; In = vecs[v].din;
            SR1 = vecs[v].sr1; SR2 = vecs[v].sr2;
            Mark = vecs[v].mark; Mark_idx = vecs[v].midx;
            settle_and_check();
            check($sformatf("vec%0d_sr1_b", v), 32'(b_sr1_out), 32'(vecs[v].e1_b));
            check($sformatf("vec%0d_sr1_n", v), 32'(n_sr1_out), 32'(vecs[v].e1_n));
            check($sformatf("vec%0d_pend2_b", v), 32'(b_sr2_pend), 32'(vecs[v].ep2_b));
            check($sformatf("vec%0d_pend2_n", v), 32'(n_sr2_pend), 32'(vecs[v].ep2_n));
            advance();
        end
        idle_inputs();

        // Fill, clear, and try a write during the third busy cycle
        for (int i = 0; i < 8; i++) begin
            Ld_REG = 1; DR = 3'(i); In = 16'(16'h1111 * i);
            step();
        end
        Ld_REG = 0; Clr_req = 1;
        step();
        Clr_req = 0;
        busy_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            Ld_REG = 0; SR1 = 3'(c % 8); SR2 = 3'd6;
            if (b_busy) busy_cnt++;
            if (b_busy && busy_cnt == 3) begin
                Ld_REG = 1; DR = 3'd6; In = 16'hFFFF; SR1 = 3'd6;
            end
            step();
        end
        Ld_REG = 0;
        check("clear8_busy_cycles", 32'(busy_cnt), 32'd8);
        for (int i = 0; i < 8; i++) begin
            SR1 = 3'(i); SR2 = 3'(i);
            settle_and_check();
            check($sformatf("after_clear_r%0d", i), 32'(b_sr1_out), 32'h0);
            advance();
        end

        // Reset during busy cycle 4 aborts the sweep
        for (int i = 0; i < 8; i++) begin
            Ld_REG = 1; DR = 3'(i); In = 16'($urandom_range(1, 16'hFFFF));
            step();
        end
        Ld_REG = 0; Mark = 1; Mark_idx = 3'd7; Clr_req = 1;
        step();
        Mark = 0; Clr_req = 0;
        busy_cnt = 1;
        for (int c = 0; c < 10 && busy_cnt < 4; c++) begin
            step();
            if (b_busy) busy_cnt++;
        end
        check("reached_busy4", 32'(busy_cnt), 32'd4);
        Reset = 1;
        step();
        Reset = 0;
        check("abort_busy", 32'(b_busy), 32'h0);
        for (int i = 0; i < 8; i++) begin
            SR1 = 3'(i); SR2 = 3'(i);
            settle_and_check();
            check($sformatf("abort_r%0d", i), 32'(b_sr1_out), 32'h0);
            check($sformatf("abort_p%0d", i), 32'(b_sr2_pend), 32'h0);
            advance();
        end

        // Randomized traffic against the model
        for (int t = 0; t < 400; t++) begin
            Reset    = ($urandom_range(0, 99) == 0);
            Ld_REG   = 1'($urandom_range(0, 1));
            DR       = 3'($urandom_range(0, 7));
            In       = 16'($urandom);
            SR1      = 3'($urandom_range(0, 7));
            SR2      = ($urandom_range(0, 2) == 0) ? DR : 3'($urandom_range(0, 7));
            Mark     = ($urandom_range(0, 2) == 0);
            Mark_idx = ($urandom_range(0, 3) == 0) ? DR : 3'($urandom_range(0, 7));
            Clr_req  = ($urandom_range(0, 24) == 0);
            step();
        end
        idle_inputs();
        step();

        // 16 x 32 instance
        @(posedge Clk); #1;
        w_reset = 0;
        w_ld = 1; w_dr = 4'd15; w_in = 32'hDEADBEEF; w_sr1 = 4'd15;
        #1;
        check("w_bypass", w_sr1_out, 32'hDEADBEEF);
        @(posedge Clk); #1;
        w_ld = 0;
        #1;
        check("w_read15", w_sr1_out, 32'hDEADBEEF);
        w_clr = 1;
        @(posedge Clk); #1;
        w_clr = 0;
        busy_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (w_busy) busy_cnt++;
            @(posedge Clk); #1;
        end
        check("w_busy_cycles", 32'(busy_cnt), 32'd16);
        check("w_r15_cleared", w_sr1_out, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
